// File: rtl/soc_uart_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : soc_uart_fifo_if
// Description : MMIO register port between the SoC decoder and the UART.
// Revision    : 1.0 - initial release
// ============================================================================
interface soc_uart_fifo_if;
    logic        addr;
    logic        write_en;
    logic [31:0] write_val;
    logic [31:0] read_val;

    modport master (output addr, write_en, write_val, input read_val);
    modport slave  (input addr, write_en, write_val, output read_val);
endinterface
`default_nettype wire

// File: rtl/soc_uart_fifo.sv
`default_nettype none
// ============================================================================
// Module      : soc_uart_fifo
// Description : Buffered UART with TX/RX FIFOs and sticky RX error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module soc_uart_fifo #(
    parameter int CLK_DIV    = 434,
    parameter int FIFO_DEPTH = 8
) (
    input  logic           clkrst_core_clk,
    input  logic           clkrst_core_rst_n,
    soc_uart_fifo_if.slave bus,
    input  logic           rx_pin,
    output logic           tx_pin
);
    localparam int c_cnt_w = $clog2(CLK_DIV);
    localparam int c_aw    = $clog2(FIFO_DEPTH);
    localparam logic [c_cnt_w-1:0] c_div_last = c_cnt_w'(CLK_DIV - 1);
    localparam logic [c_cnt_w-1:0] c_div_half = c_cnt_w'(CLK_DIV / 2 - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_aw:0]      c_ptr_one  = (c_aw + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } uart_state_t;

    logic w_wr_tx;
    logic w_wr_ctrl;
    logic w_unused;
    assign w_wr_tx   = bus.write_en && !bus.addr;
    assign w_wr_ctrl = bus.write_en &&  bus.addr;
    assign w_unused  = ^bus.write_val[31:8];

    // ------------------------------------------------------------------ TX FIFO
    logic [7:0]  r_tx_mem [FIFO_DEPTH];
    logic [c_aw:0] r_tx_wptr;
    logic [c_aw:0] r_tx_rptr;
    logic w_tx_empty;
    logic w_tx_full;
    logic w_tx_push;
    logic w_tx_pop;
    logic [7:0] w_tx_head;

    assign w_tx_empty = (r_tx_wptr == r_tx_rptr);
    assign w_tx_full  = (r_tx_wptr[c_aw] != r_tx_rptr[c_aw]) &&
                        (r_tx_wptr[c_aw-1:0] == r_tx_rptr[c_aw-1:0]);
    assign w_tx_push  = w_wr_tx && !w_tx_full;
    assign w_tx_head  = r_tx_mem[r_tx_rptr[c_aw-1:0]];

    always_ff @(posedge clkrst_core_clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wptr[c_aw-1:0]] <= bus.write_val[7:0];
    end

    always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
        if (!clkrst_core_rst_n) begin
            r_tx_wptr <= '0;
            r_tx_rptr <= '0;
        end else begin
            if (w_tx_push) r_tx_wptr <= r_tx_wptr + c_ptr_one;
            if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + c_ptr_one;
        end
    end

    // ------------------------------------------------------------------ TX FSM
    uart_state_t r_tx_state, w_tx_state_nxt;
    logic [c_cnt_w-1:0] r_tx_cnt, w_tx_cnt_nxt;
    logic [2:0] r_tx_bit, w_tx_bit_nxt;
    logic [7:0] r_tx_shift, w_tx_shift_nxt;
    logic r_tx_pin, w_tx_pin_nxt;
    logic w_tx_tick;

    assign w_tx_tick = (r_tx_cnt == c_div_last);

    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_cnt_nxt   = r_tx_cnt + c_cnt_one;
        w_tx_bit_nxt   = r_tx_bit;
        w_tx_shift_nxt = r_tx_shift;
        w_tx_pin_nxt   = r_tx_pin;
        w_tx_pop       = 1'b0;
        case (r_tx_state)
            S_IDLE: begin
                w_tx_cnt_nxt = '0;
                w_tx_pin_nxt = 1'b1;
                if (!w_tx_empty) begin
                    w_tx_pop       = 1'b1;
                    w_tx_shift_nxt = w_tx_head;
                    w_tx_pin_nxt   = 1'b0;
                    w_tx_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_tx_tick) begin
                    w_tx_cnt_nxt   = '0;
                    w_tx_bit_nxt   = 3'd0;
                    w_tx_pin_nxt   = r_tx_shift[0];
                    w_tx_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (w_tx_tick) begin
                    w_tx_cnt_nxt = '0;
                    if (r_tx_bit == 3'd7) begin
                        w_tx_pin_nxt   = 1'b1;
                        w_tx_state_nxt = S_STOP;
                    end else begin
                        w_tx_bit_nxt   = r_tx_bit + 3'd1;
                        w_tx_shift_nxt = {1'b0, r_tx_shift[7:1]};
                        w_tx_pin_nxt   = r_tx_shift[1];
                    end
                end
            end
            default: begin
                // Chaining straight into the next start bit avoids an idle gap
                if (w_tx_tick) begin
                    w_tx_cnt_nxt = '0;
                    if (!w_tx_empty) begin
                        w_tx_pop       = 1'b1;
                        w_tx_shift_nxt = w_tx_head;
                        w_tx_pin_nxt   = 1'b0;
                        w_tx_state_nxt = S_START;
                    end else begin
                        w_tx_state_nxt = S_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
        if (!clkrst_core_rst_n) r_tx_state <= S_IDLE;
        else                    r_tx_state <= w_tx_state_nxt;
    end

    always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
        if (!clkrst_core_rst_n) begin
            r_tx_cnt   <= '0;
            r_tx_bit   <= 3'd0;
            r_tx_shift <= 8'd0;
            r_tx_pin   <= 1'b1;
        end else begin
            r_tx_cnt   <= w_tx_cnt_nxt;
            r_tx_bit   <= w_tx_bit_nxt;
            r_tx_shift <= w_tx_shift_nxt;
            r_tx_pin   <= w_tx_pin_nxt;
        end
    end

    assign tx_pin = r_tx_pin;

    // ------------------------------------------------------------------ RX FSM
    logic r_rx_sync1, r_rx_sync2, r_rx_prev;
    uart_state_t r_rx_state, w_rx_state_nxt;
    logic [c_cnt_w-1:0] r_rx_cnt, w_rx_cnt_nxt;
    logic [2:0] r_rx_bit, w_rx_bit_nxt;
    logic [7:0] r_rx_shift, w_rx_shift_nxt;
    logic w_rx_done_ok;
    logic w_rx_done_err;
    logic w_rx_tick;

    assign w_rx_tick = (r_rx_cnt == c_div_last);

    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_cnt_nxt   = r_rx_cnt + c_cnt_one;
        w_rx_bit_nxt   = r_rx_bit;
        w_rx_shift_nxt = r_rx_shift;
        w_rx_done_ok   = 1'b0;
        w_rx_done_err  = 1'b0;
        case (r_rx_state)
            S_IDLE: begin
                w_rx_cnt_nxt = '0;
                if (r_rx_prev && !r_rx_sync2) w_rx_state_nxt = S_START;
            end
            S_START: begin
                if (r_rx_cnt == c_div_half) begin
                    w_rx_cnt_nxt   = '0;
                    w_rx_bit_nxt   = 3'd0;
                    w_rx_state_nxt = r_rx_sync2 ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_rx_tick) begin
                    w_rx_cnt_nxt   = '0;
                    w_rx_shift_nxt = {r_rx_sync2, r_rx_shift[7:1]};
                    w_rx_bit_nxt   = r_rx_bit + 3'd1;
                    if (r_rx_bit == 3'd7) w_rx_state_nxt = S_STOP;
                end
            end
            default: begin
                if (w_rx_tick) begin
                    w_rx_done_ok   = r_rx_sync2;
                    w_rx_done_err  = !r_rx_sync2;
                    w_rx_state_nxt = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
        if (!clkrst_core_rst_n) r_rx_state <= S_IDLE;
        else                    r_rx_state <= w_rx_state_nxt;
    end

    // r_rx_push delays the FIFO write one edge after the stop-bit sample
    logic r_rx_push;
    always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
        if (!clkrst_core_rst_n) begin
            r_rx_sync1 <= 1'b1;
            r_rx_sync2 <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_cnt   <= '0;
            r_rx_bit   <= 3'd0;
            r_rx_shift <= 8'd0;
            r_rx_push  <= 1'b0;
        end else begin
            r_rx_sync1 <= rx_pin;
            r_rx_sync2 <= r_rx_sync1;
            r_rx_prev  <= r_rx_sync2;
            r_rx_cnt   <= w_rx_cnt_nxt;
            r_rx_bit   <= w_rx_bit_nxt;
            r_rx_shift <= w_rx_shift_nxt;
            r_rx_push  <= w_rx_done_ok;
        end
    end

    // ------------------------------------------------------------------ RX FIFO
    logic [7:0]  r_rx_mem [FIFO_DEPTH];
    logic [c_aw:0] r_rx_wptr;
    logic [c_aw:0] r_rx_rptr;
    logic w_rx_empty, w_rx_full, w_rx_push, w_rx_pop, w_rx_ovr_set;
    logic r_rx_ovr, r_rx_ferr;

    assign w_rx_empty   = (r_rx_wptr == r_rx_rptr);
    assign w_rx_full    = (r_rx_wptr[c_aw] != r_rx_rptr[c_aw]) &&
                          (r_rx_wptr[c_aw-1:0] == r_rx_rptr[c_aw-1:0]);
    assign w_rx_pop     = w_wr_ctrl && bus.write_val[0] && !w_rx_empty;
    assign w_rx_push    = r_rx_push && (!w_rx_full || w_rx_pop);
    assign w_rx_ovr_set = r_rx_push && w_rx_full && !w_rx_pop;

    always_ff @(posedge clkrst_core_clk) begin
        if (w_rx_push) r_rx_mem[r_rx_wptr[c_aw-1:0]] <= r_rx_shift;
    end

    always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
        if (!clkrst_core_rst_n) begin
            r_rx_wptr <= '0;
            r_rx_rptr <= '0;
            r_rx_ovr  <= 1'b0;
            r_rx_ferr <= 1'b0;
        end else begin
            if (w_rx_push) r_rx_wptr <= r_rx_wptr + c_ptr_one;
            if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + c_ptr_one;
            if (w_wr_ctrl && bus.write_val[1]) begin
                r_rx_ovr  <= 1'b0;
                r_rx_ferr <= 1'b0;
            end
            if (w_rx_ovr_set)  r_rx_ovr  <= 1'b1;
            if (w_rx_done_err) r_rx_ferr <= 1'b1;
        end
    end

    // ------------------------------------------------------------------ readback
    logic w_tx_idle;
    assign w_tx_idle = w_tx_empty && (r_tx_state == S_IDLE);

    always_comb begin
        bus.read_val = '0;
        if (!bus.addr) begin
            bus.read_val[4:0] = {r_rx_ferr, r_rx_ovr, !w_rx_empty, w_tx_idle, w_tx_full};
        end else begin
            bus.read_val[8]   = !w_rx_empty;
            bus.read_val[7:0] = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rptr[c_aw-1:0]];
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_soc_uart_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_soc_uart_fifo
// Description : Self-checking bench for soc_uart_fifo with a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_soc_uart_fifo;
    localparam int CLK_DIV    = 16;
    localparam int FIFO_DEPTH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rx_pin = 1'b1;
    logic tx_pin;

    int n_checks = 0;
    int n_errors = 0;

    bit          mon_en = 1'b1;
    logic        mon_prev;
    logic [7:0]  mon_byte;
    logic        mon_stop;
    byte unsigned tx_exp[$];
    byte unsigned rx_exp[$];
    bit          m_ovr;
    bit          m_ferr;

    soc_uart_fifo_if u_bus ();

    soc_uart_fifo #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) u_dut (
        .clkrst_core_clk  (clk),
        .clkrst_core_rst_n(rst_n),
        .bus              (u_bus),
        .rx_pin           (rx_pin),
        .tx_pin           (tx_pin)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge
    task automatic bus_write(input logic a, input logic [31:0] v);
        u_bus.addr      = a;
        u_bus.write_val = v;
        u_bus.write_en  = 1'b1;
        @(negedge clk);
        u_bus.write_en  = 1'b0;
    endtask

    task automatic bus_read(input logic a, output logic [31:0] v);
        u_bus.addr = a;
        #1;
        v = u_bus.read_val;
    endtask

    function automatic logic [31:0] exp_status(input bit full, input bit idle);
        return {27'd0, m_ferr, m_ovr, rx_exp.size() != 0, idle, full};
    endfunction

    function automatic logic [31:0] exp_rxdata();
        if (rx_exp.size() == 0) return 32'd0;
        return {23'd0, 1'b1, rx_exp[0]};
    endfunction

    task automatic check_rx(input string tag);
        logic [31:0] v;
        bus_read(1'b0, v);
        check_val({tag, "_status"}, v, exp_status(1'b0, 1'b1));
        bus_read(1'b1, v);
        check_val({tag, "_rxdata"}, v, exp_rxdata());
    endtask

    task automatic ctrl_write(input logic [31:0] v);
        bus_write(1'b1, v);
        if (v[0] && rx_exp.size() != 0) void'(rx_exp.pop_front());
        if (v[1]) begin
            m_ovr  = 1'b0;
            m_ferr = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        rx_pin = 1'b0;
        repeat (CLK_DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_pin = b[i];
            repeat (CLK_DIV) @(negedge clk);
        end
        rx_pin = stop;
        repeat (CLK_DIV) @(negedge clk);
        rx_pin = 1'b1;
        repeat (CLK_DIV) @(negedge clk);
        if (!stop)                          m_ferr = 1'b1;
        else if (rx_exp.size() < FIFO_DEPTH) rx_exp.push_back(b);
        else                                m_ovr = 1'b1;
    endtask

    task automatic send_glitch();
        rx_pin = 1'b0;
        repeat (CLK_DIV / 4) @(negedge clk);
        rx_pin = 1'b1;
        repeat (2 * CLK_DIV) @(negedge clk);
    endtask

    task automatic wait_tx_idle(input string tag);
        logic [31:0] v;
        int          budget;
        budget = (FIFO_DEPTH + 3) * 10 * CLK_DIV;
        bus_read(1'b0, v);
        while (!v[1] && budget > 0) begin
            @(negedge clk);
            bus_read(1'b0, v);
            budget--;
        end
        check_val({tag, "_idle"}, {31'd0, v[1]}, 32'd1);
        check_val({tag, "_drained"}, tx_exp.size(), 32'd0);
    endtask

    // Transmits a burst starting from an idle transmitter: one byte goes
    // straight to the shifter, so FIFO_DEPTH+1 back-to-back writes fit.
    task automatic tx_burst(input string tag, input int n, input bit rnd);
        logic [31:0] v;
        logic [7:0]  d;
        for (int i = 0; i < n; i++) begin
            d = rnd ? 8'($urandom) : 8'(i);
            if (i < FIFO_DEPTH + 1) tx_exp.push_back(d);
            bus_write(1'b0, {24'd0, d});
        end
        bus_read(1'b0, v);
        check_val({tag, "_full"}, v, exp_status(n >= FIFO_DEPTH + 1, 1'b0));
        wait_tx_idle(tag);
    endtask

    // Independent serial receiver sampling tx_pin at each bit centre
    initial begin : p_tx_mon
        mon_prev = 1'b1;
        forever begin
            @(negedge clk);
            if (mon_en && rst_n && mon_prev && !tx_pin) begin
                repeat (CLK_DIV / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CLK_DIV) @(negedge clk);
                    mon_byte[i] = tx_pin;
                end
                repeat (CLK_DIV) @(negedge clk);
                mon_stop = tx_pin;
                if (mon_en) begin
                    check_val("tx_stop_bit", {31'd0, mon_stop}, 32'd1);
                    if (tx_exp.size() == 0) check_val("tx_unexpected", {24'd0, mon_byte}, 32'h100);
                    else                    check_val("tx_byte", {24'd0, mon_byte}, 32'(tx_exp.pop_front()));
                end
            end
            mon_prev = tx_pin;
        end
    end

    initial begin : p_watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin : p_main
        logic [31:0] v;
        int          op;
        u_bus.addr      = 1'b0;
        u_bus.write_en  = 1'b0;
        u_bus.write_val = '0;
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check_val("rst_tx_pin", {31'd0, tx_pin}, 32'd1);
        bus_read(1'b0, v);
        check_val("rst_status", v, 32'h2);
        bus_read(1'b1, v);
        check_val("rst_rxdata", v, 32'h0);

        // Single byte: latency and frame length
        tx_exp.push_back(8'h55);
        bus_write(1'b0, 32'h55);
        check_val("tx_lat_high", {31'd0, tx_pin}, 32'd1);
        bus_read(1'b0, v);
        check_val("tx_busy_status", v, 32'h0);
        @(negedge clk);
        check_val("tx_lat_low", {31'd0, tx_pin}, 32'd0);
        repeat (10 * CLK_DIV - 1) @(negedge clk);
        bus_read(1'b0, v);
        check_val("tx_idle_early", v, 32'h0);
        @(negedge clk);
        bus_read(1'b0, v);
        check_val("tx_idle_at_10bits", v, 32'h2);
        check_val("tx_single_drained", tx_exp.size(), 32'd0);

        // Fill and overflow, then random bursts
        tx_burst("tx_fill", FIFO_DEPTH + 2, 1'b0);
        for (int k = 0; k < 4; k++) tx_burst("tx_rand", $urandom_range(1, FIFO_DEPTH + 2), 1'b1);

        // RX receive and pop
        send_frame(8'hA3, 1'b1);
        check_rx("rx_a3");
        ctrl_write(32'h1);
        check_rx("rx_pop");

        // Overrun, clear, then drain
        for (int k = 0; k < FIFO_DEPTH + 1; k++) send_frame(8'($urandom), 1'b1);
        check_rx("rx_overrun");
        ctrl_write(32'h2);
        check_rx("rx_clear");
        for (int k = 0; k < FIFO_DEPTH; k++) begin
            ctrl_write(32'h1);
            check_rx("rx_drain");
        end

        // Framing error and glitch rejection
        send_frame(8'h5A, 1'b0);
        check_rx("rx_frame_err");
        ctrl_write(32'h2);
        send_glitch();
        check_rx("rx_glitch");

        // Randomized RX traffic
        for (int k = 0; k < 30; k++) begin
            op = $urandom_range(0, 7);
            if (op <= 3)      send_frame(8'($urandom), 1'b1);
            else if (op == 4) send_frame(8'($urandom), 1'b0);
            else if (op == 5) send_glitch();
            else              ctrl_write(32'($urandom_range(0, 3)));
            check_rx("rx_rand");
        end

        // Reset in the middle of a transmitted data bit
        mon_en = 1'b0;
        bus_write(1'b0, 32'h00);
        repeat (3 * CLK_DIV) @(negedge clk);
        check_val("tx_mid_low", {31'd0, tx_pin}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("tx_rst_async", {31'd0, tx_pin}, 32'd1);
        rx_exp.delete();
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus_read(1'b0, v);
        check_val("rst_mid_status", v, 32'h2);
        bus_read(1'b1, v);
        check_val("rst_mid_rxdata", v, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
